// File: rtl/noc_pkg.sv
// Shared router defaults: port/VC counts, index widths, port naming and a
// round-robin wrap helper used by the switch allocator.
package noc_pkg;

   localparam int PORT_NUM  = 5;
   localparam int VC_NUM    = 2;
   localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   typedef enum logic [PORT_SIZE-1:0] {
      LOCAL = 0,
      NORTH = 1,
      SOUTH = 2,
      WEST  = 3,
      EAST  = 4
   } port_t;

   // Next round-robin start after idx, wrapping so it never reaches n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/separable_switch_allocator_if.sv
// Request/grant bundle between the input blocks (master) and the switch
// allocator (slave); the grant side also feeds the crossbar select.
interface separable_switch_allocator_if #(
   parameter int PORT_NUM  = noc_pkg::PORT_NUM,
   parameter int VC_NUM    = noc_pkg::VC_NUM,
   parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
);

   logic [PORT_NUM-1:0][VC_NUM-1:0]                switch_request;
   logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port;
   logic [PORT_NUM-1:0][VC_NUM-1:0]                credit_avail;
   logic [PORT_NUM-1:0]                            valid_sel;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel;
   logic [PORT_NUM-1:0]                            xb_valid;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xb_in_sel;

   modport master (
      output switch_request, out_port, credit_avail,
      input  valid_sel, vc_sel, xb_valid, xb_in_sel
   );

   modport slave (
      input  switch_request, out_port, credit_avail,
      output valid_sel, vc_sel, xb_valid, xb_in_sel
   );

endinterface

// File: rtl/separable_switch_allocator_rr_arbiter.sv
// N-way round-robin arbiter: combinational pick starting at the pointer,
// pointer advances past the winner only when update_en confirms the grant.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             update_en,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   w_scan;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      w_scan      = '0;
      for (int k = 0; k < N; k++) begin
         w_scan = {1'b0, r_ptr} + (IDX_W+1)'(k);
         if (w_scan >= (IDX_W+1)'(N)) begin
            w_scan = w_scan - (IDX_W+1)'(N);
         end
         if (!grant_valid && req[w_scan[IDX_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = w_scan[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (update_en && grant_valid) begin
         r_ptr <= IDX_W'(rr_next(int'(grant_idx), N));
      end
   end

endmodule

// File: rtl/separable_switch_allocator.sv
// Separable input-first switch allocator (VC arbitration, then output arbitration).
// Define SA_OUTPUT_REG_EN to register all grant outputs (1-cycle latency).
module separable_switch_allocator #(
   parameter int PORT_NUM  = noc_pkg::PORT_NUM,
   parameter int VC_NUM    = noc_pkg::VC_NUM,
   parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
   input logic                          clk,
   input logic                          rst_n,
   separable_switch_allocator_if.slave  sa
);

   import noc_pkg::*;

   logic [PORT_NUM-1:0][VC_NUM-1:0]    w_elig;
   logic [PORT_NUM-1:0]                w_cand_valid;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_cand_vc;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_tgt;
   logic [PORT_NUM-1:0][PORT_NUM-1:0]  w_out_req;   // [output][input]
   logic [PORT_NUM-1:0][PORT_NUM-1:0]  w_win;       // [input][output]
   logic [PORT_NUM-1:0]                w_xb_valid;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_xb_sel;
   logic [PORT_NUM-1:0]                w_in_grant;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_vc_sel;

   genvar gi, gj;

   // Stage 1: one VC candidate per input; the pointer only moves if the input wins.
   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_in
         for (gj = 0; gj < VC_NUM; gj++) begin : g_vc
            assign w_elig[gi][gj] = sa.switch_request[gi][gj] & sa.credit_avail[gi][gj]
                                  & ({1'b0, sa.out_port[gi][gj]} < (PORT_SIZE+1)'(PORT_NUM));
         end

         rr_arbiter #(.N(VC_NUM), .IDX_W(VC_SIZE)) u_in_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (w_elig[gi]),
            .update_en   (w_in_grant[gi]),
            .grant_valid (w_cand_valid[gi]),
            .grant_idx   (w_cand_vc[gi])
         );

         assign w_tgt[gi]      = sa.out_port[gi][w_cand_vc[gi]];
         assign w_in_grant[gi] = |w_win[gi];
         assign w_vc_sel[gi]   = w_in_grant[gi] ? w_cand_vc[gi] : '0;
      end
   endgenerate

   // Stage 2: per output, pick one input among candidates targeting it.
   generate
      for (gj = 0; gj < PORT_NUM; gj++) begin : g_out
         for (gi = 0; gi < PORT_NUM; gi++) begin : g_req
            assign w_out_req[gj][gi] = w_cand_valid[gi] && (w_tgt[gi] == PORT_SIZE'(gj));
            assign w_win[gi][gj]     = w_xb_valid[gj] && (w_xb_sel[gj] == PORT_SIZE'(gi));
         end

         rr_arbiter #(.N(PORT_NUM), .IDX_W(PORT_SIZE)) u_out_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (w_out_req[gj]),
            .update_en   (1'b1),
            .grant_valid (w_xb_valid[gj]),
            .grant_idx   (w_xb_sel[gj])
         );
      end
   endgenerate

`ifdef SA_OUTPUT_REG_EN
   logic [PORT_NUM-1:0]                r_valid_sel;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   r_vc_sel;
   logic [PORT_NUM-1:0]                r_xb_valid;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_xb_in_sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid_sel <= '0;
         r_vc_sel    <= '0;
         r_xb_valid  <= '0;
         r_xb_in_sel <= '0;
      end else begin
         r_valid_sel <= w_in_grant;
         r_vc_sel    <= w_vc_sel;
         r_xb_valid  <= w_xb_valid;
         r_xb_in_sel <= w_xb_sel;
      end
   end

   assign sa.valid_sel = r_valid_sel;
   assign sa.vc_sel    = r_vc_sel;
   assign sa.xb_valid  = r_xb_valid;
   assign sa.xb_in_sel = r_xb_in_sel;
`else
   assign sa.valid_sel = w_in_grant;
   assign sa.vc_sel    = w_vc_sel;
   assign sa.xb_valid  = w_xb_valid;
   assign sa.xb_in_sel = w_xb_sel;
`endif

endmodule

// File: tb/tb_separable_switch_allocator.sv
// Directed bench for separable_switch_allocator (PORT_NUM=5, VC_NUM=2); works
// with or without SA_OUTPUT_REG_EN.
module tb_separable_switch_allocator;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct {
      string       tag;
      logic [4:0]  valid_sel;
      logic [4:0]  vc_sel;
      logic [4:0]  xb_valid;
      logic [14:0] xb_in_sel;
   } exp_t;

   exp_t sb[$];

   separable_switch_allocator_if #(.PORT_NUM(5), .VC_NUM(2)) sa_if ();

   separable_switch_allocator #(.PORT_NUM(5), .VC_NUM(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sa    (sa_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Crossbar select word with input i placed on output o.
   function automatic logic [14:0] xs(input int o, input int i);
      logic [14:0] r;
      r = '0;
      r[o*3 +: 3] = 3'(i);
      return r;
   endfunction

   task automatic clr();
      sa_if.switch_request = '0;
      sa_if.credit_avail   = '0;
      sa_if.out_port       = '0;
   endtask

   // Called just after a negedge with inputs already applied; returns at the next negedge.
   task automatic step(input string tag, input logic [4:0] ev, input logic [4:0] evc,
                       input logic [4:0] exv, input logic [14:0] exs);
      exp_t e;
      exp_t got;
      e.tag = tag;
      e.valid_sel = ev;
      e.vc_sel = evc;
      e.xb_valid = exv;
      e.xb_in_sel = exs;
      sb.push_back(e);
`ifdef SA_OUTPUT_REG_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
      got = sb.pop_front();
      checks++;
      assert (sa_if.valid_sel === got.valid_sel) else begin
         errors++;
         $error("FAIL %s valid_sel: got %b expected %b", got.tag, sa_if.valid_sel, got.valid_sel);
      end
      checks++;
      assert (sa_if.vc_sel === got.vc_sel) else begin
         errors++;
         $error("FAIL %s vc_sel: got %b expected %b", got.tag, sa_if.vc_sel, got.vc_sel);
      end
      checks++;
      assert (sa_if.xb_valid === got.xb_valid) else begin
         errors++;
         $error("FAIL %s xb_valid: got %b expected %b", got.tag, sa_if.xb_valid, got.xb_valid);
      end
      checks++;
      assert (sa_if.xb_in_sel === got.xb_in_sel) else begin
         errors++;
         $error("FAIL %s xb_in_sel: got %h expected %h", got.tag, sa_if.xb_in_sel, got.xb_in_sel);
      end
      $display("step %-14s valid_sel=%b vc_sel=%b xb_valid=%b xb_in_sel=%h", got.tag,
               sa_if.valid_sel, sa_if.vc_sel, sa_if.xb_valid, sa_if.xb_in_sel);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Reset with every VC requesting output 0
      rst_n = 1'b0;
      sa_if.switch_request = '1;
      sa_if.credit_avail   = '1;
      sa_if.out_port       = '0;
      @(posedge clk);
      @(negedge clk);
`ifdef SA_OUTPUT_REG_EN
      step("reset_hold", 5'b00000, 5'b00000, 5'b00000, 15'h0);
`else
      step("reset_hold", 5'b00001, 5'b00000, 5'b00001, 15'h0);
`endif
      rst_n = 1'b1;
      step("first_grant", 5'b00001, 5'b00000, 5'b00001, 15'h0);
      clr();
      step("idle_0", 5'b00000, 5'b00000, 5'b00000, 15'h0);

      // Single request: input 2 VC 1 to output 4
      sa_if.switch_request[2][1] = 1'b1;
      sa_if.credit_avail[2][1]   = 1'b1;
      sa_if.out_port[2][1]       = 3'd4;
      step("single", 5'b00100, 5'b00100, 5'b10000, xs(4, 2));
      clr();

      // All inputs VC 0 to output 1
      for (int i = 0; i < 5; i++) begin
         sa_if.switch_request[i][0] = 1'b1;
         sa_if.credit_avail[i][0]   = 1'b1;
         sa_if.out_port[i][0]       = 3'd1;
      end
      for (int k = 0; k < 10; k++) begin
         step($sformatf("contend_%0d", k), 5'(1) << (k % 5), 5'b00000, 5'b00010, xs(1, k % 5));
      end
      for (int k = 0; k < 3; k++) begin
         step($sformatf("recontend_%0d", k), 5'(1) << k, 5'b00000, 5'b00010, xs(1, k));
      end
      rst_n = 1'b0;
`ifdef SA_OUTPUT_REG_EN
      step("reset_mid", 5'b00000, 5'b00000, 5'b00000, 15'h0);
`else
      step("reset_mid", 5'b01000, 5'b00000, 5'b00010, xs(1, 3));
`endif
      rst_n = 1'b1;
      step("post_reset_0", 5'b00001, 5'b00000, 5'b00010, xs(1, 0));
      step("post_reset_1", 5'b00010, 5'b00000, 5'b00010, xs(1, 1));
      clr();
      step("idle_1", 5'b00000, 5'b00000, 5'b00000, 15'h0);

      // VC fairness on input 3: VC 0 to output 0, VC 1 to output 2
      sa_if.switch_request[3] = 2'b11;
      sa_if.credit_avail[3]   = 2'b11;
      sa_if.out_port[3][0]    = 3'd0;
      sa_if.out_port[3][1]    = 3'd2;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 1)
            step($sformatf("vc_fair_%0d", k), 5'b01000, 5'b01000, 5'b00100, xs(2, 3));
         else
            step($sformatf("vc_fair_%0d", k), 5'b01000, 5'b00000, 5'b00001, xs(0, 3));
      end
      clr();

      // Credit mask on input 1
      sa_if.switch_request[1] = 2'b11;
      sa_if.credit_avail[1]   = 2'b10;
      sa_if.out_port[1][0]    = 3'd3;
      sa_if.out_port[1][1]    = 3'd4;
      step("credit_mask", 5'b00010, 5'b00010, 5'b10000, xs(4, 1));
      sa_if.credit_avail[1][0] = 1'b1;
      step("credit_raise", 5'b00010, 5'b00000, 5'b01000, xs(3, 1));
      clr();

      // Out-of-range target is ignored; U-turn is granted
      sa_if.switch_request[4][0] = 1'b1;
      sa_if.credit_avail[4][0]   = 1'b1;
      sa_if.out_port[4][0]       = 3'd7;
      step("port_range", 5'b00000, 5'b00000, 5'b00000, 15'h0);
      sa_if.switch_request[4][1] = 1'b1;
      sa_if.credit_avail[4][1]   = 1'b1;
      sa_if.out_port[4][1]       = 3'd4;
      step("uturn", 5'b10000, 5'b10000, 5'b10000, xs(4, 4));
      clr();

      // Two independent grants in one cycle
      sa_if.switch_request[0][0] = 1'b1;
      sa_if.credit_avail[0][0]   = 1'b1;
      sa_if.out_port[0][0]       = 3'd2;
      sa_if.switch_request[2][0] = 1'b1;
      sa_if.credit_avail[2][0]   = 1'b1;
      sa_if.out_port[2][0]       = 3'd3;
      step("parallel", 5'b00101, 5'b00000, 5'b01100, xs(2, 0) | xs(3, 2));
      clr();
      step("idle_end", 5'b00000, 5'b00000, 5'b00000, 15'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/separable_switch_allocator.md
# separable_switch_allocator

Parametrised separable input-first switch allocator for the router's switch-allocation (SA) stage. It takes per-VC switch requests, target output ports and downstream credit availability from the input blocks. It grants at most one VC per input port and at most one input per output port per cycle, using round-robin fairness at both stages. Results go back to the input blocks (VC select) and to the crossbar (input select per output).

## Interface
Parameters:
- PORT_NUM, 5, number of router input/output ports
- VC_NUM, 2, virtual channels per input port
- VC_SIZE, $clog2(VC_NUM), VC index width (min 1)
- PORT_SIZE, $clog2(PORT_NUM), port index width

Ports:
- clk  input  1  router clock
- rst_n  input  1  synchronous active-low reset
- switch_request  input  [PORT_NUM][VC_NUM]  VC in SA state requests the switch
- out_port  input  [PORT_NUM][VC_NUM] x PORT_SIZE  output port targeted by each VC
- credit_avail  input  [PORT_NUM][VC_NUM]  downstream VC (already assigned to this VC) has ≥1 credit
- valid_sel  output  [PORT_NUM]  input port i won switch traversal
- vc_sel  output  [PORT_NUM] x VC_SIZE  winning VC of input i
- xb_valid  output  [PORT_NUM]  output o is driven this traversal
- xb_in_sel  output  [PORT_NUM] x PORT_SIZE  input port routed to output o

## Operation
- Eligibility: VC v of input i is eligible iff switch_request[i][v] && credit_avail[i][v] && out_port[i][v] < PORT_NUM.
- Stage 1 (input arb): per input i, round-robin over eligible VCs starting at in_ptr[i]; gives candidate c[i] with target t[i].
- Stage 2 (output arb): per output o, round-robin over inputs i with a candidate and t[i]==o, starting at out_ptr[o].
- Grant: input i granted iff it wins its output. Then valid_sel[i]=1, vc_sel[i]=c[i], xb_valid[t[i]]=1, xb_in_sel[t[i]]=i.
- Pointer update only on grant:
  - in_ptr[i] ← c[i]+1, wrapping VC_NUM-1→0.
  - out_ptr[o] ← winner+1, wrapping PORT_NUM-1→0.
  - Losing inputs keep in_ptr, so the same VC retries next cycle. This gives no starvation under persistent requests.
- Non-power-of-two VC_NUM/PORT_NUM: pointers never hold values ≥ count.
- U-turn (out_port==own input index) is allowed; no filtering.
- Ungranted outputs and inputs: valid/xb_valid=0, index fields=0.

## Timing
- Reset (rst_n=0 at posedge): all in_ptr/out_ptr ← 0; all registered outputs ← 0. Reset asserted mid-operation discards any pending grant at that edge.
- Pointers update on the posedge following the grant cycle. Request changes in the same cycle are honoured combinationally.
- Grant latency depends on SA_OUTPUT_REG_EN (see Configuration).
- Simultaneous requests from all inputs to one output: exactly one grant; the other inputs get 0.
- No request for an input: its in_ptr is unchanged.

## Configuration
- SA_OUTPUT_REG_EN defined:
  - All four output groups are registered, giving a 1-cycle latency from request to grant.
  - Pointers update on the same edge that registers the grant.
  - Outputs are 0 after reset.
  - Input blocks must drop switch_request for a granted VC in the cycle the grant is seen, not earlier.
- SA_OUTPUT_REG_EN undefined:
  - Outputs are combinational from inputs and pointers, with zero latency.
  - During reset, outputs still reflect pointers at 0.

## Structure
- noc_pkg holds PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE defaults and port_t (LOCAL, NORTH, SOUTH, WEST, EAST). out_port is compatible with port_t when PORT_NUM=5.
- Sub-module rr_arbiter, parametrised by N:
  - Inputs: clk, rst_n, req[N], update_en.
  - Outputs: grant_valid, grant_idx.
  - Contains its own pointer.
- The allocator instantiates PORT_NUM rr_arbiter(N=VC_NUM) for inputs and PORT_NUM rr_arbiter(N=PORT_NUM) for outputs.

## Test plan
- Reset: rst_n=0 for 2 cycles with all requests high → valid_sel=0, xb_valid=0 while in reset (registered build). The first post-reset grant goes to input 0, VC 0.
- Single request, input 2 VC 1 → out_port 4 with credit → valid_sel[2]=1, vc_sel[2]=1, xb_valid[4]=1, xb_in_sel[4]=2; all other valids 0.
- Output contention: inputs 0..4 all on VC 0 target output 1, held 10 cycles → grants rotate 0,1,2,3,4,0,…; exactly one grant per cycle.
- VC fairness: input 3, both VCs requesting different free outputs, held 4 cycles → vc_sel[3] alternates 0,1,0,1.
- Credit mask: input 1 VC 0 requests with credit_avail=0 and VC 1 requests with credit → only VC 1 is granted. Raising credit on VC 0 gives it the next grant.
- Reset mid-contention: after grants 0,1,2 in the contention case, pulse rst_n=0 for one cycle → the next grant is input 0, not 3.
